// File: rtl/regfile_wb_queue_if.sv
// Producer handshake plus register-file write-port bus for the write-back queue.
// The master drives results and the core write enable. The slave is the queue, which
// returns in_ready and drives the WE3/A3/WD3 write port.
interface regfile_wb_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          core_we;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    modport master (
        output in_valid, in_rd, in_data, core_we,
        input  in_ready, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_rd, in_data, core_we,
        output in_ready, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue for long-latency results. Results are buffered in a small
// FIFO and drained into the register-file write port on cycles when the main pipeline
// is not writing. Per-source pending flags let decode stall on registers still queued.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     flush,
    regfile_wb_queue_if.slave        bus,
    input  logic [AW-1:0]            rs1,
    input  logic [AW-1:0]            rs2,
    output logic                     rs1_pending,
    output logic                     rs2_pending,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    rd_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    logic empty;
    logic full;
    logic accept;
    logic push;
    logic pop;

    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));

    // No full-queue bypass: a full queue refuses even when it drains this cycle.
    assign bus.in_ready = rst && !flush && !full;
    assign accept       = bus.in_valid && bus.in_ready;
    // Writes to x0 complete the handshake but are discarded.
    assign push         = accept && (bus.in_rd != '0);

    // The core write port always wins; the queue simply waits.
    assign pop          = rst && !empty && !bus.core_we;
    assign bus.wb_we    = pop;
    assign bus.wb_addr  = (rst && !empty) ? rd_q[rd_ptr]   : '0;
    assign bus.wb_data  = (rst && !empty) ? data_q[rd_ptr] : '0;
    assign count        = cnt;

    // Control state: pointers, occupancy and entry valid bits.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + 1'b1;
                vld_q[wr_ptr]  <= 1'b1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                vld_q[rd_ptr]  <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge CLK) begin
        if (push) begin
            rd_q[wr_ptr]   <= bus.in_rd;
            data_q[wr_ptr] <= bus.in_data;
        end
    end

    // Pending lookup: the entry draining this cycle still counts until its pop edge.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rd_q[i] == rs1) && (rs1 != '0)) rs1_pending = 1'b1;
            if (vld_q[i] && (rd_q[i] == rs2) && (rs2 != '0)) rs2_pending = 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus a randomized run, all checked
// against a queue-based model of the write-back FIFO.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic        rs1_pending, rs2_pending;
    logic [2:0]  count;
    int          total = 0;
    int          bad = 0;
    ent_t        mq[$];

    regfile_wb_queue_if #(.AW(5), .DW(32)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .CLK(CLK), .rst(rst_n), .flush(flush), .bus(bus),
        .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .count(count)
    );

    always #5 CLK = ~CLK;

    function automatic bit exp_we();
        return rst_n && (mq.size() != 0) && !bus.core_we;
    endfunction

    function automatic bit exp_pend(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_rdy();
        return rst_n && !flush && (mq.size() < DEPTH);
    endfunction

    // Advance one clock edge and apply the same transaction to the model.
    task automatic tick();
        bit   acc, pop;
        ent_t e;
        acc = rst_n && bus.in_valid && !flush && (mq.size() < DEPTH);
        pop = rst_n && (mq.size() != 0) && !bus.core_we;
        e.rd = bus.in_rd;
        e.d  = bus.in_data;
        @(posedge CLK);
        #1;
        if (!rst_n || flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc && e.rd != 0) mq.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_rd = 0; bus.in_data = 0; bus.core_we = 0;
        flush = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; rs1 = 5'd1; bus.in_valid = 1; bus.in_rd = 5'd1; bus.in_data = 32'hFFFF_FFFF;
        #2;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", bus.in_ready); end
        total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b want=0", bus.wb_we); end
        total++; if (bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin bad++; $display("FAIL rst_bus got=%0d/%h want=0/0", bus.wb_addr, bus.wb_data); end
        total++; if (count !== 3'd0 || rs1_pending !== 1'b0) begin bad++; $display("FAIL rst_cnt got=%0d/%0b want=0/0", count, rs1_pending); end
        tick();
        idle_inputs();
        rst_n = 1; #2;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%0b want=1", bus.in_ready); end
        // Queue two entries behind the core, then start draining and reset mid-cycle.
        bus.core_we = 1; bus.in_valid = 1; bus.in_rd = 5'd3; bus.in_data = 32'h33;
        tick(); tick();
        bus.in_valid = 0; bus.core_we = 0; #2;
        total++; if (bus.wb_we !== 1'b1 || count !== 3'd2) begin bad++; $display("FAIL pre_rst got=%0b/%0d want=1/2", bus.wb_we, count); end
        rst_n = 0; mq.delete(); #1;
        total++; if (bus.wb_we !== 1'b0 || count !== 3'd0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0b/%0d/%0b want=0/0/0", bus.wb_we, count, bus.in_ready); end
        tick();
        rst_n = 1; #2;
        total++; if (bus.in_ready !== 1'b1 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL rel2 got=%0b/%0b want=1/0", bus.in_ready, bus.wb_we); end
    endtask

    task automatic test_single();
        idle_inputs();
        rs1 = 5'd5; bus.in_valid = 1; bus.in_rd = 5'd5; bus.in_data = 32'hDEAD_BEEF; #2;
        total++; if (bus.in_ready !== 1'b1 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL single_pre got=%0b/%0b want=1/0", bus.in_ready, bus.wb_we); end
        tick();
        bus.in_valid = 0; #2;
        total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wb got=%0b/%0d/%h want=1/5/deadbeef", bus.wb_we, bus.wb_addr, bus.wb_data); end
        total++; if (rs1_pending !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL single_pend got=%0b/%0d want=1/1", rs1_pending, count); end
        tick(); #1;
        total++; if (bus.wb_we !== 1'b0 || rs1_pending !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL single_post got=%0b/%0b/%0d want=0/0/0", bus.wb_we, rs1_pending, count); end
    endtask

    task automatic test_fill();
        logic [31:0] dv [5];
        idle_inputs();
        bus.core_we = 1;
        for (int i = 1; i <= 4; i++) begin
            dv[i] = $urandom;
            bus.in_valid = 1; bus.in_rd = 5'(i); bus.in_data = dv[i];
            tick();
        end
        bus.in_rd = 5'd9; bus.in_data = 32'h9999; #1;
        total++; if (count !== 3'd4 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%0d/%0b want=4/0", count, bus.in_ready); end
        tick(); #1;
        total++; if (count !== 3'd4 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL fill_5th got=%0d/%0b want=4/0", count, bus.wb_we); end
        bus.in_valid = 0; bus.core_we = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'(i) || bus.wb_data !== dv[i]) begin bad++; $display("FAIL fill_drain%0d got=%0b/%0d/%h want=1/%0d/%h", i, bus.wb_we, bus.wb_addr, bus.wb_data, i, dv[i]); end
            tick();
        end
        #1;
        total++; if (bus.wb_we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL fill_end got=%0b/%0d want=0/0", bus.wb_we, count); end
    endtask

    task automatic test_wrap();
        ent_t exp[$];
        idle_inputs();
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                bus.in_valid = 1; bus.in_rd = 5'($urandom_range(1, 31)); bus.in_data = $urandom;
                exp.push_back({bus.in_rd, bus.in_data});
            end else bus.in_valid = 0;
            #1;
            total++; if (count > 3'd1) begin bad++; $display("FAIL wrap_cnt got=%0d want<=1", count); end
            if (i > 0) begin
                total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== exp[0].rd || bus.wb_data !== exp[0].d) begin bad++; $display("FAIL wrap_wb%0d got=%0b/%0d/%h want=1/%0d/%h", i, bus.wb_we, bus.wb_addr, bus.wb_data, exp[0].rd, exp[0].d); end
                void'(exp.pop_front());
            end
            tick();
        end
    endtask

    task automatic test_x0_dup();
        idle_inputs();
        rs2 = 5'd7;
        bus.in_valid = 1; bus.in_rd = 5'd0; bus.in_data = 32'h55;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0b want=1", bus.in_ready); end
        tick(); bus.in_valid = 0; #1;
        total++; if (bus.wb_we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL x0_drop got=%0b/%0d want=0/0", bus.wb_we, count); end
        bus.core_we = 1;
        bus.in_valid = 1; bus.in_rd = 5'd7; bus.in_data = 32'h11; tick();
        bus.in_data = 32'h22; tick();
        bus.in_valid = 0; bus.core_we = 0; #1;
        total++; if (bus.wb_addr !== 5'd7 || bus.wb_data !== 32'h11 || rs2_pending !== 1'b1) begin bad++; $display("FAIL dup_first got=%0d/%h/%0b want=7/11/1", bus.wb_addr, bus.wb_data, rs2_pending); end
        tick(); #1;
        total++; if (bus.wb_we !== 1'b1 || bus.wb_data !== 32'h22 || rs2_pending !== 1'b1) begin bad++; $display("FAIL dup_second got=%0b/%h/%0b want=1/22/1", bus.wb_we, bus.wb_data, rs2_pending); end
        tick(); #1;
        total++; if (rs2_pending !== 1'b0 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL dup_done got=%0b/%0b want=0/0", rs2_pending, bus.wb_we); end
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.core_we = 1; rs1 = 5'd12; rs2 = 5'd13;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_rd = 5'(11 + i); bus.in_data = $urandom; tick();
        end
        bus.core_we = 0; flush = 1; bus.in_rd = 5'd20; #1;
        total++; if (bus.in_ready !== 1'b0 || bus.wb_we !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL flush_same got=%0b/%0b/%0d want=0/1/3", bus.in_ready, bus.wb_we, count); end
        tick();
        flush = 0; bus.in_valid = 0; #1;
        total++; if (count !== 3'd0 || rs1_pending !== 1'b0 || rs2_pending !== 1'b0 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL flush_after got=%0d/%0b/%0b/%0b want=0/0/0/0", count, rs1_pending, rs2_pending, bus.wb_we); end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_rd    = 5'($urandom_range(0, 7));
            bus.in_data  = $urandom;
            bus.core_we  = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 31) == 0);
            rs1          = 5'($urandom_range(0, 7));
            rs2          = 5'($urandom_range(0, 7));
            #2;
            total++; if (bus.wb_we !== exp_we()) begin bad++; $display("FAIL rnd_we c=%0d got=%0b want=%0b", c, bus.wb_we, exp_we()); end
            if (mq.size() != 0) begin
                total++; if (bus.wb_addr !== mq[0].rd || bus.wb_data !== mq[0].d) begin bad++; $display("FAIL rnd_head c=%0d got=%0d/%h want=%0d/%h", c, bus.wb_addr, bus.wb_data, mq[0].rd, mq[0].d); end
            end
            total++; if (bus.in_ready !== exp_rdy() || count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_rdycnt c=%0d got=%0b/%0d want=%0b/%0d", c, bus.in_ready, count, exp_rdy(), mq.size()); end
            total++; if (rs1_pending !== exp_pend(rs1) || rs2_pending !== exp_pend(rs2)) begin bad++; $display("FAIL rnd_pend c=%0d got=%0b/%0b want=%0b/%0b", c, rs1_pending, rs2_pending, exp_pend(rs1), exp_pend(rs2)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_x0_dup();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
